// File: rtl/serial_pkg.sv
// Shared constants for the serial deserializer: buffer state encoding, frame length and counter sizing.
// Parity option follows SERIAL_PARITY_EN.
package serial_pkg;

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

`ifdef SERIAL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Bits per frame: data bits plus an optional trailing parity bit.
    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_counter.sv
// mod_n_counter: enable-driven counter that wraps at N, asynchronous active-low clear.
// tc is high while the count sits at N-1, so tc & en marks the wrapping edge.
module mod_n_counter #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Double-buffered MSB-first deserializer with Valid/Ack output and sticky Overrun.
// Optional even parity bit after the data bits when SERIAL_PARITY_EN is defined.
module serial_to_parallel
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             notReset,
    input  logic             D,
    input  logic             Shift,
    input  logic             Ack,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Overrun,
    output logic             ParityErr
);

    localparam int FRAME = frame_len(WIDTH, PARITY_EN);
    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             complete;
    logic             data_phase;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             state;

    mod_n_counter #(
        .N (FRAME),
        .W (CNT_W)
    ) u_cnt (
        .clk   (Clk),
        .rst_n (notReset),
        .en    (Shift),
        .count (cnt),
        .tc    (tc)
    );

    assign complete   = tc & Shift;
    // The parity bit position never enters sr, so sr always holds pure data.
    assign data_phase = (cnt < CNT_W'(WIDTH));

`ifdef SERIAL_PARITY_EN
    assign word      = sr;
    assign word_perr = (^sr) ^ D;
`else
    assign word      = {sr[WIDTH-2:0], D};
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            sr <= '0;
        end else if (Shift && data_phase) begin
            sr <= {sr[WIDTH-2:0], D};
        end
    end

    always_ff @(posedge Clk or negedge notReset) begin
        if (!notReset) begin
            state     <= EMPTY;
            Q         <= '0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (complete) begin
                        Q         <= word;
                        ParityErr <= word_perr;
                        state     <= FULL;
                    end
                end
                default: begin
                    if (Ack) begin
                        if (complete) begin
                            Q         <= word;
                            ParityErr <= word_perr;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (complete) begin
                        Overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign Valid = state;

endmodule
